stack_reader: RTL and testbench

STACK_READER -- requirements
Module: stack_reader

---
 rtl/stack_reader.sv | 140 ++++++++++++++
 tb/tb_stack_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_reader.sv
// ---------------------------------------------------------------------------
// stack_reader
//
// Dumps the contents of an externally stored stack, top entry first, into a
// valid/ready stream. The entry index is read from a synchronous storage port
// whose data returns one cycle after the address. The stack depth is captured
// when the dump starts. The dump can be aborted at any point before DONE.
//
// Ports
//   Clk       in   single clock, rising edge
//   Rst       in   synchronous active-high reset
//   Start     in   request a dump (sampled in IDLE only)
//   Abort     in   cancel an in-progress dump (READ/CAPT/OUT)
//   Depth     in   top-of-stack index; 0 = empty, entries at 1..Depth
//   RdAddr    out  storage read address (registered, holds outside READ)
//   RdData    in   storage read data, valid one cycle after RdAddr
//   OutData   out  entry offered downstream
//   OutValid  out  OutData holds a valid entry
//   OutReady  in   downstream accepts the entry
//   OutLast   out  offered entry is index 1 (bottom of stack)
//   Busy      out  high in every state except IDLE
//   Done      out  one-cycle pulse when a dump completes
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start
// READ  | RdAddr = ptr presented to storage
// CAPT  | storage data returns, registered into OutData
// OUT   | entry offered; advance on OutReady, finish after index 1
// DONE  | one-cycle Done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module stack_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] Depth,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              ptr_is_one;

    assign ptr_is_one = (ptr == ADDR_W'(1));

    always_comb begin
        state_nxt = state;
        OutValid  = 1'b0;
        OutLast   = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;
        case (state)
            ST_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    state_nxt = (Depth != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                state_nxt = Abort ? ST_IDLE : ST_CAPT;
            end
            ST_CAPT: begin
                state_nxt = Abort ? ST_IDLE : ST_OUT;
            end
            ST_OUT: begin
                OutValid = 1'b1;
                OutLast  = ptr_is_one;
                // Abort beats a simultaneous OutReady: the beat is not taken.
                if (Abort) begin
                    state_nxt = ST_IDLE;
                end else if (OutReady) begin
                    state_nxt = ptr_is_one ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                Done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // RdAddr is loaded together with ptr on every transition into READ, so it
    // already equals ptr for the whole READ cycle and simply holds elsewhere.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            RdAddr  <= '0;
            OutData <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (Start && (Depth != '0)) begin
                        ptr    <= Depth;
                        RdAddr <= Depth;
                    end
                end
                ST_CAPT: begin
                    if (!Abort) begin
                        OutData <= RdData;
                    end
                end
                ST_OUT: begin
                    // ptr stops at 1: the last beat goes to DONE instead.
                    if (OutReady && !Abort && !ptr_is_one) begin
                        ptr    <= ptr - ADDR_W'(1);
                        RdAddr <= ptr - ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_reader.sv
module tb_stack_reader;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Abort;
    logic [7:0]  Depth;
    logic [7:0]  RdAddr;
    logic [15:0] RdData;
    logic [15:0] OutData;
    logic        OutValid;
    logic        OutReady;
    logic        OutLast;
    logic        Busy;
    logic        Done;

    stack_reader #(.DATA_W(16), .ADDR_W(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Abort    (Abort),
        .Depth    (Depth),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutLast  (OutLast),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Storage model: synchronous read, data one cycle after address.
    logic [15:0] mem [0:255];
    always @(posedge Clk) RdData <= mem[RdAddr];

    // Scoreboard state
    logic [15:0] exp_q  [$];
    bit          last_q [$];
    int          checks     = 0;
    int          errors     = 0;
    int          done_count = 0;
    int          beat_count = 0;
    bit          done_due   = 0;
    bit          zero_dump  = 0;
    bit          lat_arm    = 0;
    int          lat_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every offered beat with the head of the expected queue
    // and pops on a real transfer; also polices Done and first-beat latency.
    always @(negedge Clk) begin
        if (Rst) begin
            done_due = 0;
        end else begin
            if (done_due) begin
                chk("done_after_last", 32'(Done), 32'd1);
                done_due = 0;
            end else if (Done && !zero_dump) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end
            if (Done) done_count++;

            if (lat_arm) begin
                lat_cnt++;
                if (OutValid) begin
                    chk("first_valid_latency", 32'(lat_cnt), 32'd3);
                    lat_arm = 0;
                end else if (lat_cnt > 8) begin
                    chk("first_valid_seen", 32'(OutValid), 32'd1);
                    lat_arm = 0;
                end
            end

            if (OutValid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_with_empty_queue", 32'(OutValid), 32'd0);
                end else begin
                    chk("out_data", 32'(OutData), 32'(exp_q[0]));
                    chk("out_last", 32'(OutLast), 32'(last_q[0]));
                    if (OutReady && !Abort) begin
                        if (last_q[0]) done_due = 1;
                        void'(exp_q.pop_front());
                        void'(last_q.pop_front());
                        beat_count++;
                    end
                end
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = {8'($urandom), 8'(i)};
    endtask

    task automatic push_expected(input int depth);
        for (int i = depth; i >= 1; i--) begin
            exp_q.push_back(mem[i]);
            last_q.push_back(i == 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_outvalid"}, 32'(OutValid), 32'd0);
        chk({tag, "_outlast"},  32'(OutLast),  32'd0);
        chk({tag, "_busy"},     32'(Busy),     32'd0);
        chk({tag, "_done"},     32'(Done),     32'd0);
        chk({tag, "_outdata"},  32'(OutData),  32'd0);
        chk({tag, "_rdaddr"},   32'(RdAddr),   32'd0);
    endtask

    // One full dump: Start with the given depth, then drive OutReady with the
    // given acceptance rate (optionally stalling the first beat) until Done.
    task automatic do_dump(input int depth, input int ready_pct, input bit noise, input int stall);
        int d0;
        int cyc;
        int stall_left;
        d0         = done_count;
        stall_left = stall;
        cyc        = 0;
        push_expected(depth);
        zero_dump = (depth == 0);
        Depth     = 8'(depth);
        Rst       = 1'b0;
        Start     = 1'b1;
        OutReady  = ($urandom_range(0, 99) < ready_pct);
        @(posedge Clk); #1;
        Start = 1'b0;
        if (depth != 0) begin
            lat_cnt = 0;
            lat_arm = 1;
        end
        while (done_count == d0 && cyc < 4000) begin
            if (stall_left > 0 && OutValid) begin
                OutReady = 1'b0;
                stall_left--;
            end else begin
                OutReady = ($urandom_range(0, 99) < ready_pct);
            end
            if (noise) begin
                Depth = 8'($urandom);
                Start = 1'($urandom_range(0, 1));
            end
            @(posedge Clk); #1;
            cyc++;
        end
        Start     = 1'b0;
        zero_dump = 0;
        lat_arm   = 0;
        chk("dump_done_count", 32'(done_count - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_after_dump", 32'(Busy), 32'd0);
        exp_q.delete();
        last_q.delete();
    endtask

    initial begin
        int cyc;
        int b0;
        int d0;

        Rst      = 1'b1;
        Start    = 1'b0;
        Abort    = 1'b0;
        Depth    = 8'd0;
        OutReady = 1'b0;
        fill_mem();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Depth 3, always ready
        mem[3] = 16'h0033;
        mem[2] = 16'h0022;
        mem[1] = 16'h0011;
        do_dump(3, 100, 0, 0);
        fill_mem();

        // Empty stack: DONE straight away, one busy cycle
        d0 = done_count;
        zero_dump = 1;
        Depth = 8'd0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        chk("empty_done", 32'(Done), 32'd1);
        chk("empty_busy", 32'(Busy), 32'd1);
        chk("empty_valid", 32'(OutValid), 32'd0);
        @(negedge Clk);
        chk("empty_done_end", 32'(Done), 32'd0);
        chk("empty_busy_end", 32'(Busy), 32'd0);
        zero_dump = 0;
        chk("empty_done_pulses", 32'(done_count - d0), 32'd1);
        @(posedge Clk); #1;

        // Depth 2, first beat stalled for 5 cycles
        do_dump(2, 100, 0, 5);

        // Depth 4, abort in OUT of the second beat with OutReady also high
        push_expected(4);
        Depth    = 8'd4;
        Start    = 1'b1;
        OutReady = 1'b1;
        b0       = beat_count;
        d0       = done_count;
        @(posedge Clk); #1;
        Start = 1'b0;
        cyc   = 0;
        while (!(OutValid && beat_count == b0 + 1) && cyc < 50) begin
            @(posedge Clk); #1;
            cyc++;
        end
        chk("abort_reached_beat2", 32'(cyc < 50), 32'd1);
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        exp_q.delete();
        last_q.delete();
        chk("abort_outvalid", 32'(OutValid), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        repeat (6) @(posedge Clk);
        #1;
        chk("abort_no_done", 32'(done_count - d0), 32'd0);
        do_dump(1, 100, 0, 0);

        // Reset in CAPT of a depth 5 dump
        push_expected(5);
        d0    = done_count;
        Depth = 8'd5;
        Start = 1'b1;
        OutReady = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        exp_q.delete();
        last_q.delete();
        @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("midreset");
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("midreset_no_done", 32'(done_count - d0), 32'd0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        // Start on the first edge after reset releases
        do_dump(3, 100, 0, 0);

        // Full depth with random backpressure and noisy Start/Depth
        fill_mem();
        do_dump(255, 50, 1, 0);

        // Random dumps
        for (int n = 0; n < 10; n++) begin
            fill_mem();
            do_dump($urandom_range(0, 30), $urandom_range(20, 100), 1, $urandom_range(0, 3));
        end

        repeat (3) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
